// File: rtl/axi_write_slave_burst_if.sv
// AXI3 write-channel bundle plus the memory-side beat port of axi_write_slave_burst.
// The slave modport is the design view; the master modport drives it (interconnect/memory side).
interface axi_write_slave_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ready;
    logic                write_done;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        output mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready,
        output write_done
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        input  mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready,
        input  write_done
    );
endinterface

// File: rtl/axi_write_slave_burst.sv
// AXI3 write slave: one burst at a time, FIXED/INCR/WRAP beat addressing, strobed beats to a memory port.
// Optional macro AXI_WID_CHECK_EN compares WID against the captured AWID on every beat.
module axi_write_slave_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input logic                    ACLK,
    input logic                    ARESET,
    axi_write_slave_burst_if.slave bus
);
    localparam int SIZE_MAX = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t             state;
    state_t             state_nx;
    logic               awready;
    logic [ID_W-1:0]    cap_id;
    logic [ADDR_W-1:0]  cap_addr;
    logic [LEN_W-1:0]   cap_len;
    logic [2:0]         cap_size;
    logic [1:0]         cap_burst;
    logic [LEN_W-1:0]   cnt;
    logic               err;
    logic               aw_hs;
    logic               beat;
    logic               last_beat;
    logic               wid_err;
    logic               beat_err;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] mask;
        incr = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b01:   next_addr = (addr & ~(incr - ADDR_W'(1))) + incr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic aw_error(
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic bad_len;
        logic misaligned;
        bad_len    = !((len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                       (len == LEN_W'(7)) || (len == LEN_W'(15)));
        misaligned = (addr & ((ADDR_W'(1) << size) - ADDR_W'(1))) != '0;
        aw_error   = (size > 3'(SIZE_MAX)) || (burst == 2'b11) ||
                     ((burst == 2'b10) && (bad_len || misaligned));
    endfunction

    assign aw_hs     = (state == IDLE) && awready && bus.AWVALID;
    assign beat      = (state == DATA) && bus.WVALID && bus.mem_ready;
    assign last_beat = (cnt == cap_len);
`ifdef AXI_WID_CHECK_EN
    assign wid_err   = (bus.WID != cap_id);
`else
    assign wid_err   = 1'b0;
`endif
    // WLAST only qualifies the burst; termination comes from the beat counter
    assign beat_err  = (bus.WLAST != last_beat) || wid_err;

    assign bus.AWREADY   = awready;
    assign bus.mem_addr  = cap_addr;
    assign bus.mem_wdata = bus.WDATA;
    assign bus.mem_wstrb = bus.WSTRB;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            awready <= 1'b0;
        end else begin
            state   <= state_nx;
            awready <= (state_nx == IDLE);
        end
    end

    always_comb begin
        state_nx       = state;
        bus.WREADY     = 1'b0;
        bus.BVALID     = 1'b0;
        bus.BID        = '0;
        bus.BRESP      = 2'b00;
        bus.mem_we     = 1'b0;
        bus.write_done = 1'b0;
        case (state)
            IDLE: begin
                if (aw_hs) state_nx = DATA;
            end
            DATA: begin
                bus.WREADY = bus.mem_ready;
                if (beat) begin
                    bus.mem_we = !err && !beat_err;
                    if (last_beat) state_nx = RESP;
                end
            end
            RESP: begin
                bus.BVALID = 1'b1;
                bus.BID    = cap_id;
                bus.BRESP  = err ? 2'b10 : 2'b00;
                if (bus.BREADY) begin
                    bus.write_done = 1'b1;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cap_id    <= '0;
            cap_addr  <= '0;
            cap_len   <= '0;
            cap_size  <= '0;
            cap_burst <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else if (aw_hs) begin
            cap_id    <= bus.AWID;
            cap_addr  <= bus.AWADDR;
            cap_len   <= bus.AWLEN;
            cap_size  <= bus.AWSIZE;
            cap_burst <= bus.AWBURST;
            cnt       <= '0;
            err       <= aw_error(bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST);
        end else if (beat) begin
            cnt      <= cnt + LEN_W'(1);
            cap_addr <= next_addr(cap_addr, cap_len, cap_size, cap_burst);
            if (beat_err) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_write_slave_burst.sv
// Randomised and directed bench for axi_write_slave_burst with a queue-based scoreboard.
module tb_axi_write_slave_burst;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 0;
    wr_t  wq[$];
    b_t   bq[$];

    logic [31:0] bdata[16];
    logic [3:0]  bstrb[16];
    logic        blast[16];
    logic [3:0]  bwid[16];

    always #5 ACLK = ~ACLK;

    axi_write_slave_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_write_slave_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat address from the burst rules, expressed as offsets rather than a running register
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len, input int size,
                                               input int burst, input int n);
        logic [31:0] incr, total, base;
        incr = 32'd1 << size;
        if (burst == 1) begin
            if (n == 0) return a;
            return (a - (a % incr)) + 32'(n) * incr;
        end else if (burst == 2) begin
            total = 32'(len + 1) * incr;
            base  = a - (a % total);
            return base + (((a - base) + 32'(n) * incr) % total);
        end
        return a;
    endfunction

    task automatic plan_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input int burst, input int bad_beat,
                              input int wid_bad, input bit push_b, input int keep_beats);
        bit err;
        bit bad;
        wr_t w;
        b_t b;
        err = (size > 2) || (burst == 3) ||
              ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              ((burst == 2) && ((addr % (32'd1 << size)) != 0));
        for (int n = 0; n <= len; n++) begin
            bdata[n] = $urandom;
            bstrb[n] = 4'($urandom_range(0, 15));
            blast[n] = (n == len) ^ (n == bad_beat);
            bwid[n]  = (n == wid_bad) ? ~id : id;
            bad = (blast[n] != (n == len));
`ifdef AXI_WID_CHECK_EN
            bad = bad || (bwid[n] != id);
`endif
            if (!err && !bad && n < keep_beats) begin
                w.addr = model_addr(addr, len, size, burst, n);
                w.data = bdata[n];
                w.strb = bstrb[n];
                wq.push_back(w);
            end
            if (bad) err = 1'b1;
        end
        if (push_b) begin
            b.id   = id;
            b.resp = err ? 2'b10 : 2'b00;
            bq.push_back(b);
        end
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = 4'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWBURST = 2'(burst);
        bus.AWVALID = 1'b1;
    endtask

    task automatic wait_aw();
        bit hs;
        int k = 0;
        do begin
            @(negedge ACLK);
            hs = bus.AWREADY;
            @(posedge ACLK);
            #1;
            k++;
        end while (!hs && k < 200);
        chk("aw_handshake", hs, 1);
        bus.AWVALID = 1'b0;
    endtask

    task automatic do_w(input int beats, input bit gaps);
        bit hs;
        int k;
        for (int n = 0; n < beats; n++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.WVALID = 1'b0;
                @(posedge ACLK);
                #1;
            end
            bus.WVALID = 1'b1;
            bus.WDATA  = bdata[n];
            bus.WSTRB  = bstrb[n];
            bus.WLAST  = blast[n];
            bus.WID    = bwid[n];
            k = 0;
            do begin
                @(negedge ACLK);
                hs = bus.WREADY;
                @(posedge ACLK);
                #1;
                k++;
            end while (!hs && k < 200);
            if (!hs) chk("w_handshake", hs, 1);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic wait_bvalid();
        bit v;
        int k = 0;
        do begin
            @(negedge ACLK);
            v = bus.BVALID;
            k++;
        end while (!v && k < 100);
        chk("bvalid_wait", v, 1);
    endtask

    task automatic do_b(input int delay);
        wait_bvalid();
        repeat (delay) @(negedge ACLK);
        @(posedge ACLK);
        #1;
        bus.BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input int burst, input int bad_beat,
                             input int wid_bad, input bit gaps, input int delay);
        plan_burst(id, addr, len, size, burst, bad_beat, wid_bad, 1'b1, 16);
        set_aw(id, addr, len, size, burst);
        wait_aw();
        do_w(len + 1, gaps);
        do_b(delay);
    endtask

    always @(posedge ACLK) begin
        #1;
        case (rdy_mode)
            0:       bus.mem_ready = 1'b1;
            1:       bus.mem_ready = ~bus.mem_ready;
            default: bus.mem_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge ACLK) begin
        wr_t w;
        if (!ARESET) begin
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    chk("mem_we_unexpected", bus.mem_we, 0);
                end else begin
                    w = wq.pop_front();
                    chk("mem_addr", bus.mem_addr, w.addr);
                    chk("mem_wdata", bus.mem_wdata, w.data);
                    chk("mem_wstrb", bus.mem_wstrb, w.strb);
                end
            end
            if (bus.WVALID) chk("wready_gated", bus.WREADY & ~bus.mem_ready, 0);
            if (bus.BVALID || bus.write_done)
                chk("write_done", bus.write_done, bus.BVALID & bus.BREADY);
            if (bus.BVALID) begin
                chk("awready_in_resp", bus.AWREADY, 0);
                if (bq.size() == 0) begin
                    chk("bvalid_unexpected", bus.BVALID, 0);
                end else begin
                    chk("bid", bus.BID, bq[0].id);
                    chk("bresp", bus.BRESP, bq[0].resp);
                    if (bus.BREADY) void'(bq.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, bus.AWREADY, 0);
        chk({tag, "_wready"}, bus.WREADY, 0);
        chk({tag, "_bvalid"}, bus.BVALID, 0);
        chk({tag, "_bresp"}, bus.BRESP, 0);
        chk({tag, "_bid"}, bus.BID, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_write_done"}, bus.write_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int len, size, burst, bad, widb;
        logic [31:0] addr;
        bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0;
        bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.WVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.BREADY = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset state and AWREADY rising one cycle after release
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_outputs("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_first_cycle", bus.AWREADY, 0);
        @(negedge ACLK);
        chk("awready_rise", bus.AWREADY, 1);
        @(posedge ACLK);
        #1;

        run_burst(4'd5, 32'h100, 3, 2, 1, -1, -1, 1'b0, 0);
        run_burst(4'd6, 32'h38, 3, 2, 2, -1, -1, 1'b0, 0);
        rdy_mode = 1;
        run_burst(4'd7, 32'h20, 2, 2, 0, -1, -1, 1'b0, 0);
        rdy_mode = 0;
        run_burst(4'd8, 32'h0, 3, 3, 1, -1, -1, 1'b0, 0);
        run_burst(4'd1, 32'h80, 3, 2, 1, 1, -1, 1'b0, 1);

        // BREADY held low with the next AW already pending
        plan_burst(4'd9, 32'h400, 3, 2, 1, -1, -1, 1'b1, 16);
        set_aw(4'd9, 32'h400, 3, 2, 1);
        wait_aw();
        do_w(4, 1'b0);
        plan_burst(4'd10, 32'h500, 1, 1, 1, -1, -1, 1'b1, 16);
        set_aw(4'd10, 32'h500, 1, 1, 1);
        wait_bvalid();
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("hold_bvalid", bus.BVALID, 1);
            chk("hold_awready", bus.AWREADY, 0);
        end
        @(posedge ACLK);
        #1;
        bus.BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        bus.BREADY = 1'b0;
        @(negedge ACLK);
        chk("awready_after_b", bus.AWREADY, 1);
        @(posedge ACLK);
        #1;
        bus.AWVALID = 1'b0;
        do_w(2, 1'b0);
        do_b(0);

        // Reset in the middle of a LEN=7 burst
        plan_burst(4'd3, 32'h200, 7, 2, 1, -1, -1, 1'b0, 2);
        set_aw(4'd3, 32'h200, 7, 2, 1);
        wait_aw();
        do_w(2, 1'b0);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        bus.WVALID = 1'b1;
        @(negedge ACLK);
        chk_reset_outputs("midreset");
        chk("midreset_wq", 32'(wq.size()), 0);
        @(posedge ACLK);
        #1;
        bus.WVALID = 1'b0;
        ARESET = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        run_burst(4'd4, 32'h300, 3, 2, 1, -1, -1, 1'b0, 0);

`ifdef AXI_WID_CHECK_EN
        run_burst(4'd2, 32'h600, 3, 2, 1, -1, 2, 1'b0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == 2 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = 32'($urandom_range(0, 16'hFFFF));
            if (burst == 2 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 1);
            bad  = ($urandom_range(0, 6) == 0) ? $urandom_range(0, len) : -1;
`ifdef AXI_WID_CHECK_EN
            widb = ($urandom_range(0, 6) == 0) ? $urandom_range(0, len) : -1;
`else
            widb = -1;
`endif
            rdy_mode = $urandom_range(0, 2);
            run_burst(4'($urandom_range(0, 15)), addr, len, size, burst, bad, widb, 1'b1,
                      $urandom_range(0, 3));
        end
        rdy_mode = 0;

        repeat (3) @(negedge ACLK);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("bq_empty", 32'(bq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
